// File: rtl/microcode_sequencer_if.sv
// Issue/handshake/configuration bus between the microcode sequencer and its datapath.
// The master side drives opcode, flags, stall/resume and table writes; the slave side issues control words.
interface microcode_sequencer_if #(
    parameter int OPW    = 4,
    parameter int FLAGW  = 2,
    parameter int PHASES = 2,
    parameter int CTRLW  = 13
);
    localparam int PB = $clog2(PHASES);
    localparam int AW = OPW + FLAGW + PB;

    logic [OPW-1:0]   instr;
    logic [FLAGW-1:0] flags_in;
    logic             flags_we;
    logic             ready;
    logic             resume;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [CTRLW-1:0] cfg_data;
    logic [CTRLW-1:0] ctrl;
    logic             valid;
    logic [PB-1:0]    phase;
    logic [OPW-1:0]   opcode;
    logic             halted;

    modport master (
        output instr, flags_in, flags_we, ready, resume, cfg_we, cfg_addr, cfg_data,
        input  ctrl, valid, phase, opcode, halted
    );

    modport slave (
        input  instr, flags_in, flags_we, ready, resume, cfg_we, cfg_addr, cfg_data,
        output ctrl, valid, phase, opcode, halted
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Programmable microcode control unit: phase counter, opcode latch, flag register and a
// writable {opcode, flags, phase}-indexed control-word table with stall, halt/resume.
module microcode_sequencer #(
    parameter int               OPW        = 4,
    parameter int               FLAGW      = 2,
    parameter int               PHASES     = 2,
    parameter int               CTRLW      = 13,
    parameter int               HALT_BIT   = 0,
    parameter logic [CTRLW-1:0] DEFAULT_CW = 13'h1008
) (
    input logic                  clk,
    input logic                  reset,
    microcode_sequencer_if.slave bus
);
    localparam int PB      = $clog2(PHASES);
    localparam int AW      = OPW + FLAGW + PB;
    localparam int ENTRIES = 2 ** AW;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CTRLW-1:0] table_r [ENTRIES];
    logic [CTRLW-1:0] ctrl_r;
    logic [CTRLW-1:0] ctrl_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic [PB-1:0]    phase_r;
    logic [PB-1:0]    phase_nxt_s;
    logic [OPW-1:0]   opcode_r;
    logic [OPW-1:0]   opcode_nxt_s;
    logic [FLAGW-1:0] flags_r;
    logic             halted_r;
    logic [OPW-1:0]   op_sel_s;
    logic [AW-1:0]    addr_s;
    logic [CTRLW-1:0] word_s;
    logic             last_phase_s;

    // Lookup address: the fetch phase decodes the incoming opcode, later phases the latched one.
    always_comb begin
        op_sel_s     = (phase_r == PB'(0)) ? bus.instr : opcode_r;
        addr_s       = {op_sel_s, flags_r, phase_r};
        word_s       = table_r[addr_s];
        last_phase_s = (phase_r == PB'(PHASES - 1));
    end

    // Next-state and next-output decode for the RUN/HALT machine.
    always_comb begin
        state_nxt_s  = state_r;
        ctrl_nxt_s   = CTRLW'(0);
        valid_nxt_s  = 1'b0;
        phase_nxt_s  = phase_r;
        opcode_nxt_s = opcode_r;
        case (state_r)
            ST_RUN: begin
                if (bus.ready) begin
                    ctrl_nxt_s   = word_s;
                    valid_nxt_s  = 1'b1;
                    opcode_nxt_s = op_sel_s;
                    if (word_s[HALT_BIT]) begin
                        state_nxt_s = ST_HALT;
                        phase_nxt_s = PB'(0);
                    end else if (last_phase_s) begin
                        state_nxt_s = ST_RUN;
                        phase_nxt_s = PB'(0);
                    end else begin
                        state_nxt_s = ST_RUN;
                        phase_nxt_s = phase_r + PB'(1);
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                // Phase was forced to 0 on entry, so resuming restarts at the fetch phase.
                if (bus.resume) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                phase_nxt_s = PB'(0);
            end
        endcase
    end

    // FSM state and registered issue outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            ctrl_r   <= CTRLW'(0);
            valid_r  <= 1'b0;
            phase_r  <= PB'(0);
            opcode_r <= OPW'(0);
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            valid_r  <= valid_nxt_s;
            phase_r  <= phase_nxt_s;
            opcode_r <= opcode_nxt_s;
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

    // Flag register loads in any state; the same-cycle lookup still sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= FLAGW'(0);
        end else if (bus.flags_we) begin
            flags_r <= bus.flags_in;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Control-word table; a write becomes visible to lookups from the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= DEFAULT_CW;
            end
        end else if (bus.cfg_we) begin
            table_r[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    assign bus.ctrl   = ctrl_r;
    assign bus.valid  = valid_r;
    assign bus.phase  = phase_r;
    assign bus.opcode = opcode_r;
    assign bus.halted = halted_r;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed vector table, reset corner cases,
// then randomized traffic against a behavioural table/phase model.
module tb_microcode_sequencer;
    localparam int OPW = 4, FLAGW = 2, PHASES = 2, CTRLW = 13;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    microcode_sequencer_if #(.OPW(OPW), .FLAGW(FLAGW), .PHASES(PHASES), .CTRLW(CTRLW)) bus ();

    microcode_sequencer #(
        .OPW(OPW), .FLAGW(FLAGW), .PHASES(PHASES), .CTRLW(CTRLW),
        .HALT_BIT(0), .DEFAULT_CW(13'h1008)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  instr;
        logic [1:0]  fin;
        logic        fwe;
        logic        rdy;
        logic        res;
        logic        cwe;
        logic [6:0]  caddr;
        logic [12:0] cdata;
        logic [12:0] e_ctrl;
        logic        e_valid;
        logic        e_phase;
        logic [3:0]  e_op;
        logic        e_halt;
    } vec_t;

    vec_t vecs [31];

    // behavioural model state
    logic [12:0] m_tbl [128];
    int          m_phase;
    int          m_op;
    int          m_flags;
    bit          m_halt;
    logic [12:0] m_ctrl;
    bit          m_valid;

    function automatic vec_t mk(logic [3:0] instr, logic [1:0] fin, logic fwe, logic rdy,
                                logic res, logic cwe, logic [6:0] caddr, logic [12:0] cdata,
                                logic [12:0] e_ctrl, logic e_valid, logic e_phase,
                                logic [3:0] e_op, logic e_halt);
        vec_t v;
        v.instr = instr; v.fin = fin; v.fwe = fwe; v.rdy = rdy; v.res = res;
        v.cwe = cwe; v.caddr = caddr; v.cdata = cdata;
        v.e_ctrl = e_ctrl; v.e_valid = e_valid; v.e_phase = e_phase;
        v.e_op = e_op; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [12:0] c, input logic v,
                             input logic p, input logic [3:0] o, input logic h);
        check({tag, ".ctrl"},   32'(bus.ctrl),   32'(c));
        check({tag, ".valid"},  32'(bus.valid),  32'(v));
        check({tag, ".phase"},  32'(bus.phase),  32'(p));
        check({tag, ".opcode"}, 32'(bus.opcode), 32'(o));
        check({tag, ".halted"}, 32'(bus.halted), 32'(h));
    endtask

    task automatic drive(input logic [3:0] instr, input logic [1:0] fin, input logic fwe,
                         input logic rdy, input logic res, input logic cwe,
                         input logic [6:0] caddr, input logic [12:0] cdata);
        bus.instr = instr; bus.flags_in = fin; bus.flags_we = fwe; bus.ready = rdy;
        bus.resume = res; bus.cfg_we = cwe; bus.cfg_addr = caddr; bus.cfg_data = cdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_tbl[i] = 13'h1008;
        m_phase = 0; m_op = 0; m_flags = 0; m_halt = 1'b0; m_ctrl = 13'h0; m_valid = 1'b0;
    endtask

    // One clock of the sequencer, from the current inputs, in plain arithmetic.
    task automatic model_step();
        int          sel;
        logic [12:0] w;
        if (m_halt) begin
            m_ctrl = 13'h0; m_valid = 1'b0;
            if (bus.resume) m_halt = 1'b0;
        end else if (bus.ready) begin
            sel = (m_phase == 0) ? int'(bus.instr) : m_op;
            w = m_tbl[sel * 8 + m_flags * 2 + m_phase];
            m_ctrl = w; m_valid = 1'b1; m_op = sel;
            if (w[0]) begin
                m_halt = 1'b1; m_phase = 0;
            end else begin
                m_phase = (m_phase + 1) % PHASES;
            end
        end else begin
            m_ctrl = 13'h0; m_valid = 1'b0;
        end
        if (bus.flags_we) m_flags = int'(bus.flags_in);
        if (bus.cfg_we) m_tbl[bus.cfg_addr] = bus.cfg_data;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        drive(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 13'h0000);

        //            instr  fin    fwe   rdy   res   cwe   caddr  cdata      ctrl       v     ph    op     h
        vecs[0]  = mk(4'h3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h3, 1'b0);
        vecs[1]  = mk(4'h3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b0, 4'h3, 1'b0);
        vecs[2]  = mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h19, 13'h0AB8, 13'h0000, 1'b0, 1'b0, 4'h3, 1'b0);
        vecs[3]  = mk(4'h3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h3, 1'b0);
        vecs[4]  = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0AB8, 1'b1, 1'b0, 4'h3, 1'b0);
        vecs[5]  = mk(4'h3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h3, 1'b0);
        vecs[6]  = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 7'h19, 13'h0122, 13'h0AB8, 1'b1, 1'b0, 4'h3, 1'b0);
        vecs[7]  = mk(4'h3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h3, 1'b0);
        vecs[8]  = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0122, 1'b1, 1'b0, 4'h3, 1'b0);
        vecs[9]  = mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h1D, 13'h0550, 13'h0000, 1'b0, 1'b0, 4'h3, 1'b0);
        vecs[10] = mk(4'h3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h3, 1'b0);
        vecs[11] = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0550, 1'b1, 1'b0, 4'h3, 1'b0);
        vecs[12] = mk(4'h3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h3, 1'b0);
        vecs[13] = mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0000, 1'b0, 1'b1, 4'h3, 1'b0);
        vecs[14] = mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0000, 1'b0, 1'b1, 4'h3, 1'b0);
        vecs[15] = mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0000, 1'b0, 1'b1, 4'h3, 1'b0);
        vecs[16] = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0550, 1'b1, 1'b0, 4'h3, 1'b0);
        vecs[17] = mk(4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0000, 1'b0, 1'b0, 4'h3, 1'b0);
        vecs[18] = mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h29, 13'h0001, 13'h0000, 1'b0, 1'b0, 4'h3, 1'b0);
        vecs[19] = mk(4'h5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h5, 1'b0);
        vecs[20] = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0001, 1'b1, 1'b0, 4'h5, 1'b1);
        vecs[21] = mk(4'h3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0000, 1'b0, 1'b0, 4'h5, 1'b1);
        vecs[22] = mk(4'h3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 13'h0000, 13'h0000, 1'b0, 1'b0, 4'h5, 1'b0);
        vecs[23] = mk(4'h3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h3, 1'b0);
        vecs[24] = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0122, 1'b1, 1'b0, 4'h3, 1'b0);
        vecs[25] = mk(4'h5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h1008, 1'b1, 1'b1, 4'h5, 1'b0);
        vecs[26] = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0001, 1'b1, 1'b0, 4'h5, 1'b1);
        vecs[27] = mk(4'h5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h28, 13'h0AAA, 13'h0000, 1'b0, 1'b0, 4'h5, 1'b0);
        vecs[28] = mk(4'h5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0AAA, 1'b1, 1'b1, 4'h5, 1'b0);
        vecs[29] = mk(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000, 13'h0001, 1'b1, 1'b0, 4'h5, 1'b1);
        vecs[30] = mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 13'h0000, 13'h0000, 1'b0, 1'b0, 4'h5, 1'b0);

        #12;
        check_all("reset", 13'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].instr, vecs[i].fin, vecs[i].fwe, vecs[i].rdy, vecs[i].res,
                  vecs[i].cwe, vecs[i].caddr, vecs[i].cdata);
            cycle();
            check_all($sformatf("vec%0d", i), vecs[i].e_ctrl, vecs[i].e_valid,
                      vecs[i].e_phase, vecs[i].e_op, vecs[i].e_halt);
        end

        // async reset mid-execute, then programmed entries must read back the default
        drive(4'h5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000);
        cycle();
        check_all("pre_rst_exec", 13'h0AAA, 1'b1, 1'b1, 4'h5, 1'b0);
        reset = 1'b0;
        #1;
        check_all("rst_mid_exec", 13'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
        #2;
        reset = 1'b1;
        drive(4'h5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000);
        cycle();
        check_all("default_fetch", 13'h1008, 1'b1, 1'b1, 4'h5, 1'b0);
        cycle();
        check_all("default_exec", 13'h1008, 1'b1, 1'b0, 4'h5, 1'b0);

        // async reset while halted
        drive(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h29, 13'h0001);
        cycle();
        drive(4'h5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 13'h0000);
        cycle();
        cycle();
        check_all("halt_issue", 13'h0001, 1'b1, 1'b0, 4'h5, 1'b1);
        cycle();
        check_all("halt_hold", 13'h0000, 1'b0, 1'b0, 4'h5, 1'b1);
        reset = 1'b0;
        #1;
        check_all("rst_in_halt", 13'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
        drive(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 13'h0000);
        #2;
        reset = 1'b1;

        // randomized traffic against the behavioural model
        model_reset();
        for (int i = 0; i < 600; i++) begin
            logic [12:0] d;
            d = 13'($urandom_range(0, 8191));
            d[0] = ($urandom_range(0, 7) == 0);
            drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                  7'($urandom_range(0, 127)), d);
            model_step();
            cycle();
            check_all($sformatf("rand%0d", i), m_ctrl, m_valid, 1'(m_phase), 4'(m_op), m_halt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
